// File: rtl/spi_jstk_pkg.sv
// Shared constants, state type and frame builder for the PmodJSTK SPI slave emulator.
package spi_jstk_pkg;

    localparam int FRAME_BITS = 40;
    localparam int BYTE_W     = 8;

    // Byte 0 is the first byte on the wire and occupies the frame MSBs.
    localparam int X_LO = 0;
    localparam int X_HI = 1;
    localparam int Y_LO = 2;
    localparam int Y_HI = 3;
    localparam int BTN  = 4;

    localparam int LED_BYTE = 0;
    localparam int LED_LSB  = 0;
    localparam int LED_W    = 2;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    function automatic int byte_lsb(input int idx);
        return FRAME_BITS - BYTE_W * (idx + 1);
    endfunction

    function automatic logic [FRAME_BITS-1:0] jstk_frame(input logic [9:0] x,
                                                         input logic [9:0] y,
                                                         input logic [2:0] btn);
        logic [FRAME_BITS-1:0] f;
        f = '0;
        f[byte_lsb(X_LO) +: BYTE_W] = x[7:0];
        f[byte_lsb(X_HI) +: 2]      = x[9:8];
        f[byte_lsb(Y_LO) +: BYTE_W] = y[7:0];
        f[byte_lsb(Y_HI) +: 2]      = y[9:8];
        f[byte_lsb(BTN)  +: 3]      = btn;
        return f;
    endfunction

endpackage

// File: rtl/spi_jstk_slave_if.sv
// SPI pins plus joystick-side payload/status for the PmodJSTK slave emulator.
interface spi_jstk_slave_if #(
    parameter int FRAME_BITS = spi_jstk_pkg::FRAME_BITS
);
    logic                  cs;
    logic                  sck;
    logic                  mosi;
    logic                  miso;
    logic [9:0]            x_pos;
    logic [9:0]            y_pos;
    logic [2:0]            btn;
    logic [FRAME_BITS-1:0] rx_bytes;
    logic                  rx_valid;
    logic [1:0]            led;
    logic                  frame_err;

    modport slave (
        input  cs, sck, mosi, x_pos, y_pos, btn,
        output miso, rx_bytes, rx_valid, led, frame_err
    );

    modport master (
        output cs, sck, mosi, x_pos, y_pos, btn,
        input  miso, rx_bytes, rx_valid, led, frame_err
    );
endinterface

// File: rtl/spi_jstk_slave_sync_edge.sv
// Multi-flop input synchronizer with registered rise/fall pulses aligned to the synchronized level.
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic lvl_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rise_q;
    logic                   fall_q;

    // Edges are taken one stage early so each pulse lines up with the level it reports.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            rise_q <=  sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1];
            fall_q <= ~sync_q[SYNC_STAGES-2] &  sync_q[SYNC_STAGES-1];
        end
    end

    assign lvl_o  = sync_q[SYNC_STAGES-1];
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/spi_jstk_slave.sv
// SPI mode-0 slave emulating the PmodJSTK joystick; oversamples cs/sck/mosi in the clk domain.
// Define SPI_JSTK_FRAME_CHECK_EN to reject frames that are not exactly FRAME_BITS long.
module spi_jstk_slave #(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = spi_jstk_pkg::FRAME_BITS
) (
    input  logic            clk,
    input  logic            rst,
    spi_jstk_slave_if.slave bus
);
    import spi_jstk_pkg::*;

    localparam int CNT_MAX = FRAME_BITS + 1;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int PAD     = FRAME_BITS - spi_jstk_pkg::FRAME_BITS;
    localparam int LED_POS = FRAME_BITS - BYTE_W * (LED_BYTE + 1) + LED_LSB;

`ifdef SPI_JSTK_FRAME_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic cs_rise, cs_fall, sck_rise, sck_fall, mosi_s;
    logic unused_cs_lvl, unused_sck_lvl, unused_mosi_rise, unused_mosi_fall;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
        .clk(clk), .rst(rst), .d_i(bus.cs),
        .lvl_o(unused_cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
        .clk(clk), .rst(rst), .d_i(bus.sck),
        .lvl_o(unused_sck_lvl), .rise_o(sck_rise), .fall_o(sck_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk(clk), .rst(rst), .d_i(bus.mosi),
        .lvl_o(mosi_s), .rise_o(unused_mosi_rise), .fall_o(unused_mosi_fall)
    );

    state_t                state_q;
    logic [FRAME_BITS-1:0] tx_sr_q;
    logic [FRAME_BITS-1:0] rx_sr_q;
    logic [CNT_W-1:0]      bit_cnt_q;
    logic                  miso_q;
    logic [FRAME_BITS-1:0] rx_bytes_q;
    logic [LED_W-1:0]      led_q;
    logic                  rx_valid_q;
    logic                  frame_err_q;

    logic [FRAME_BITS-1:0] tx_snap_d;
    logic                  frame_ok_d;

    // Payload sits MSB-aligned if the frame is configured wider than the native 5 bytes.
    assign tx_snap_d = FRAME_BITS'(jstk_frame(bus.x_pos, bus.y_pos, bus.btn)) << PAD;

`ifdef SPI_JSTK_FRAME_CHECK_EN
    assign frame_ok_d = (bit_cnt_q == CNT_W'(FRAME_BITS));
`else
    assign frame_ok_d = (bit_cnt_q != '0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            tx_sr_q     <= '0;
            rx_sr_q     <= '0;
            bit_cnt_q   <= '0;
            miso_q      <= 1'b0;
            rx_bytes_q  <= '0;
            led_q       <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_q   <= SHIFT;
                        tx_sr_q   <= tx_snap_d;
                        rx_sr_q   <= '0;
                        bit_cnt_q <= '0;
                        miso_q    <= tx_snap_d[FRAME_BITS-1];
                    end
                end
                SHIFT: begin
                    if (cs_rise) begin
                        state_q <= IDLE;
                        miso_q  <= 1'b0;
                        if (frame_ok_d) begin
                            rx_bytes_q <= rx_sr_q;
                            led_q      <= rx_sr_q[LED_POS +: LED_W];
                            rx_valid_q <= 1'b1;
                        end else begin
                            frame_err_q <= CHECK_EN;
                        end
                    end else begin
                        if (sck_rise) begin
                            rx_sr_q <= {rx_sr_q[FRAME_BITS-2:0], mosi_s};
                            if (bit_cnt_q != CNT_W'(CNT_MAX)) begin
                                bit_cnt_q <= bit_cnt_q + 1'b1;
                            end
                        end
                        // Zero fill makes miso read 0 once every payload bit has gone out.
                        if (sck_fall) begin
                            tx_sr_q <= {tx_sr_q[FRAME_BITS-2:0], 1'b0};
                            miso_q  <= tx_sr_q[FRAME_BITS-2];
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.miso      = miso_q;
    assign bus.rx_bytes  = rx_bytes_q;
    assign bus.led       = led_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_jstk_slave.sv
// Directed bench for spi_jstk_slave: bit-banged SPI master plus a scoreboard of end-of-frame pulses.
module tb_spi_jstk_slave;

    localparam int SYNC_STAGES = 2;
    localparam int H = SYNC_STAGES + 3;

    typedef struct {
        logic [1:0]  kind;
        logic [39:0] rx;
        logic [1:0]  led;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_jstk_slave_if bus();

    spi_jstk_slave #(.SYNC_STAGES(SYNC_STAGES)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_fail = 0;
    int n_valid = 0;
    int n_err = 0;
    int exp_valid = 0;
    int exp_err = 0;
    exp_t sb[$];
    logic [39:0] model_rx = '0;
    logic [1:0] model_led = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pop one expectation per end-of-frame pulse and compare the outputs it should carry.
    always @(negedge clk) begin
        if (!rst && (bus.rx_valid || bus.frame_err)) begin
            if (bus.rx_valid) n_valid++;
            if (bus.frame_err) n_err++;
            if (sb.size() == 0) begin
                chk("unexpected_pulse", {62'd0, bus.rx_valid, bus.frame_err}, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("pulse_kind", {62'd0, bus.rx_valid, bus.frame_err}, {62'd0, e.kind});
                chk("rx_bytes", {24'd0, bus.rx_bytes}, {24'd0, e.rx});
                chk("led", {62'd0, bus.led}, {62'd0, e.led});
            end
        end
    end

    task automatic push_expect(input logic [63:0] tx, input int nbits);
        exp_t e;
        bit ok;
`ifdef SPI_JSTK_FRAME_CHECK_EN
        ok = (nbits == 40);
`else
        ok = (nbits >= 1);
`endif
        if (ok) begin
            model_rx  = tx[39:0];
            model_led = tx[33:32];
            e.kind = 2'b10;
            exp_valid++;
        end else begin
            e.kind = 2'b01;
            exp_err++;
        end
        e.rx  = model_rx;
        e.led = model_led;
        sb.push_back(e);
    endtask

    task automatic shift_bits(input logic [63:0] tx, input int nbits, input int chg_at,
                              input logic [9:0] chg_x, output logic [63:0] got);
        got = '0;
        for (int i = 0; i < nbits; i++) begin
            if (i == chg_at) bus.x_pos = chg_x;
            bus.mosi = tx[nbits-1-i];
            clks(H);
            got = {got[62:0], bus.miso};
            bus.sck = 1'b1;
            clks(H);
            bus.sck = 1'b0;
        end
    endtask

    task automatic frame(input string tag, input logic [63:0] tx, input int nbits,
                         input logic [63:0] exp_miso, input int gap,
                         input int chg_at, input logic [9:0] chg_x);
        logic [63:0] got;
        bus.cs = 1'b0;
        clks(H);
        shift_bits(tx, nbits, chg_at, chg_x, got);
        clks(H);
        push_expect(tx, nbits);
        bus.cs = 1'b1;
        clks(gap);
        chk(tag, got, exp_miso);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] got;
        int v0, e0;
        rst = 1'b1;
        bus.cs = 1'b1;
        bus.sck = 1'b0;
        bus.mosi = 1'b0;
        bus.x_pos = 10'h2A5;
        bus.y_pos = 10'h13C;
        bus.btn = 3'b101;
        clks(5);
        rst = 1'b0;
        clks(1);
        chk("rst_miso", {63'd0, bus.miso}, 64'd0);
        chk("rst_rx_bytes", {24'd0, bus.rx_bytes}, 64'd0);
        chk("rst_rx_valid", {63'd0, bus.rx_valid}, 64'd0);
        chk("rst_led", {62'd0, bus.led}, 64'd0);
        chk("rst_frame_err", {63'd0, bus.frame_err}, 64'd0);
        clks(5);

        frame("miso_basic", 64'h8100000000, 40, 64'hA5023C0105, 10, -1, 10'h0);
        frame("miso_midchg", 64'h0211223344, 40, 64'hA5023C0105, 10, 8, 10'h3FF);
        frame("miso_after_chg", 64'h01AABBCCDD, 40, 64'hFF033C0105, 10, -1, 10'h0);
        frame("miso_short", 64'hC0FFEE, 24, 64'hFF033C, 10, -1, 10'h0);
        frame("miso_long", 64'h12_3756789ABC, 48, 64'hFF033C010500, 10, -1, 10'h0);

        // Reset in the middle of a frame with cs held low throughout.
        v0 = n_valid;
        e0 = n_err;
        bus.cs = 1'b0;
        clks(H);
        shift_bits(64'hFFFFF, 20, -1, 10'h0, got);
        rst = 1'b1;
        clks(3);
        rst = 1'b0;
        model_rx = '0;
        model_led = '0;
        clks(10);
        chk("rstmid_miso", {63'd0, bus.miso}, 64'd0);
        chk("rstmid_rx_bytes", {24'd0, bus.rx_bytes}, 64'd0);
        chk("rstmid_led", {62'd0, bus.led}, 64'd0);
        bus.cs = 1'b1;
        clks(10);
        chk("rstmid_no_valid", 64'(n_valid - v0), 64'd0);
        chk("rstmid_no_err", 64'(n_err - e0), 64'd0);
        frame("miso_post_rst", 64'h0300000000, 40, 64'hFF033C0105, 10, -1, 10'h0);
        chk("led_post_rst", {62'd0, bus.led}, 64'd3);

        frame("miso_b2b_a", 64'h0100000001, 40, 64'hFF033C0105, 2, -1, 10'h0);
        frame("miso_b2b_b", 64'h02FFFFFFFF, 40, 64'hFF033C0105, 2, -1, 10'h0);
        frame("miso_b2b_c", 64'h0312345678, 40, 64'hFF033C0105, 10, -1, 10'h0);

        clks(10);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        chk("valid_count", 64'(n_valid), 64'(exp_valid));
        chk("err_count", 64'(n_err), 64'(exp_err));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
